bit_sum_accumulator: RTL and testbench

//  Pipelined, parametrised popcount-and-accumulate for the acquire engine.
//  - Each valid cycle: counts the ones in an IN_WIDTH-bit word of correlator sign-match bits.
//  - Adds that count over a run-time number of words (coherent length), then emits one dump.
//  - Sits between the sign-match array and the non-coherent/peak-search stage.

---
 rtl/acq_engine_pkg.sv | 35 +++
 rtl/group_popcount.sv | 20 ++
 rtl/bit_sum_accumulator.sv | 172 +++++++++++++++++
 tb/tb_bit_sum_accumulator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_engine_pkg.sv
// Shared constants and helpers for the acquire-engine popcount path.
// Contents:
//   pop_width()  - width of a popcount of an N-bit word
//   acc_width()  - popcount width plus coherent-length counter width
//   num_groups() - ceil(in_width / group_w)
//   NUM_GROUPS   - group count for the default 31-bit / 7-bit configuration
//   state_t      - IDLE / ACCUM state encoding
package acq_engine_pkg;

    localparam int unsigned DEF_IN_WIDTH = 31;
    localparam int unsigned DEF_GROUP_W  = 7;
    localparam int unsigned DEF_CNT_W    = 10;

    function automatic int unsigned pop_width(input int unsigned in_width);
        return $clog2(in_width + 1);
    endfunction

    function automatic int unsigned acc_width(input int unsigned in_width,
                                              input int unsigned cnt_w);
        return pop_width(in_width) + cnt_w;
    endfunction

    function automatic int unsigned num_groups(input int unsigned in_width,
                                               input int unsigned group_w);
        return (in_width + group_w - 1) / group_w;
    endfunction

    localparam int unsigned NUM_GROUPS = num_groups(DEF_IN_WIDTH, DEF_GROUP_W);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/group_popcount.sv
// Combinational count of ones in one GROUP_W-bit group.
// Ports:
//   bits     in   GROUP_W              group of sign-match bits
//   count_c  out  clog2(GROUP_W+1)     number of ones (combinational)
module group_popcount #(
    parameter int unsigned GROUP_W = 7
) (
    input  logic [GROUP_W-1:0]            bits,
    output logic [$clog2(GROUP_W+1)-1:0]  count_c
);
    localparam int unsigned CW = $clog2(GROUP_W + 1);

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < GROUP_W; i++) begin
            count_c = count_c + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/bit_sum_accumulator.sv
// Pipelined popcount-and-accumulate: counts ones per valid word and sums the
// counts over a run of acc_len words, then emits one dump.
// Build option: define BIT_SUM_SIGNED_OUT_EN for a signed +/-1 correlation sum
// (each word contributes 2*pc - IN_WIDTH, sum_out is ACC_W+1 bits).
// Ports:
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset
//   start      in   1          load acc_len, clear state, begin a run
//   acc_len    in   CNT_W      words per run (0 treated as 1)
//   in_valid   in   1          in_data valid
//   in_data    in   IN_WIDTH   sign-match bits
//   busy       out  1          run in progress
//   sum_valid  out  1          one-cycle dump pulse
//   sum_out    out  OUT_W      accumulated result, held between dumps
module bit_sum_accumulator
    import acq_engine_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 31,
    parameter int unsigned GROUP_W  = 7,
    parameter int unsigned CNT_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    acc_len,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                busy,
    output logic                sum_valid,
`ifdef BIT_SUM_SIGNED_OUT_EN
    output logic [acc_width(IN_WIDTH, CNT_W):0]   sum_out
`else
    output logic [acc_width(IN_WIDTH, CNT_W)-1:0] sum_out
`endif
);
    localparam int unsigned POP_W = pop_width(IN_WIDTH);
    localparam int unsigned ACC_W = acc_width(IN_WIDTH, CNT_W);
    localparam int unsigned NG    = num_groups(IN_WIDTH, GROUP_W);
    localparam int unsigned GC_W  = $clog2(GROUP_W + 1);
    localparam int unsigned PAD_W = NG * GROUP_W;
`ifdef BIT_SUM_SIGNED_OUT_EN
    localparam int unsigned OUT_W = ACC_W + 1;
`else
    localparam int unsigned OUT_W = ACC_W;
`endif

    // Zero-pad so the last (partial) group reads zeros above IN_WIDTH.
    logic [PAD_W-1:0]         padded_c;
    logic [NG-1:0][GC_W-1:0]  grp_cnt_c;

    assign padded_c = PAD_W'(in_data);

    for (genvar g = 0; g < NG; g++) begin : g_grp
        group_popcount #(
            .GROUP_W (GROUP_W)
        ) u_pop (
            .bits    (padded_c[g*GROUP_W +: GROUP_W]),
            .count_c (grp_cnt_c[g])
        );
    end

    // Pipeline S1 (group counts) and S2 (total popcount)
    logic [NG-1:0][GC_W-1:0]  s1_cnt;
    logic                     s1_valid;
    logic [POP_W-1:0]         s2_pc;
    logic                     s2_valid;
    logic [POP_W-1:0]         pc_c;

    always_comb begin
        pc_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            pc_c = pc_c + POP_W'(s1_cnt[g]);
        end
    end

    // start drops words already in flight but keeps the word arriving with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cnt   <= '0;
            s1_valid <= 1'b0;
            s2_pc    <= '0;
            s2_valid <= 1'b0;
        end else begin
            s1_cnt   <= grp_cnt_c;
            s1_valid <= in_valid;
            s2_pc    <= pc_c;
            s2_valid <= start ? 1'b0 : s1_valid;
        end
    end

    // Per-word contribution to the accumulator
    logic [OUT_W-1:0] contrib_c;
`ifdef BIT_SUM_SIGNED_OUT_EN
    assign contrib_c = (OUT_W'(s2_pc) << 1) - OUT_W'(IN_WIDTH);
`else
    assign contrib_c = OUT_W'(s2_pc);
`endif

    // Run control FSM
    state_t           state, state_n;
    logic [CNT_W-1:0] len, len_n;
    logic [CNT_W-1:0] count, count_n;
    logic [OUT_W-1:0] acc, acc_n;
    logic [OUT_W-1:0] sum_n;
    logic             sum_valid_n;
    logic             busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= CNT_W'(1);
            count     <= '0;
            acc       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            count     <= count_n;
            acc       <= acc_n;
            sum_out   <= sum_n;
            sum_valid <= sum_valid_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len;
        count_n     = count;
        acc_n       = acc;
        sum_n       = sum_out;
        sum_valid_n = 1'b0;
        busy_n      = busy;

        if (start) begin
            // start wins over any dump due in the same cycle
            state_n = ACCUM;
            len_n   = (acc_len == '0) ? CNT_W'(1) : acc_len;
            count_n = '0;
            acc_n   = '0;
            busy_n  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    busy_n = 1'b0;
                end
                ACCUM: begin
                    if (s2_valid) begin
                        if (count == len - CNT_W'(1)) begin
                            sum_n       = acc + contrib_c;
                            sum_valid_n = 1'b1;
                            acc_n       = '0;
                            count_n     = '0;
                            state_n     = IDLE;
                            busy_n      = 1'b0;
                        end else begin
                            acc_n   = acc + contrib_c;
                            count_n = count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_sum_accumulator.sv
// Directed self-checking bench for bit_sum_accumulator (31-bit words, CNT_W=10).
module tb_bit_sum_accumulator;

`ifdef BIT_SUM_SIGNED_OUT_EN
    localparam int unsigned OUT_W = 16;
`else
    localparam int unsigned OUT_W = 15;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [9:0]       acc_len;
    logic             in_valid;
    logic [30:0]      in_data;
    logic             busy;
    logic             sum_valid;
    logic [OUT_W-1:0] sum_out;

    int n_cmp;
    int n_bad;
    int dumps;

    localparam logic [30:0] ONES = 31'h7FFF_FFFF;

    bit_sum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_len   (acc_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .sum_valid (sum_valid),
        .sum_out   (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count dump pulses independently of the directed checks.
    always @(posedge clk) begin
        if (sum_valid === 1'b1) dumps <= dumps + 1;
    end

    // Expected value for the build: unsigned popcount sum or signed correlation.
    function automatic logic [OUT_W-1:0] pick(input int u, input int s);
`ifdef BIT_SUM_SIGNED_OUT_EN
        return OUT_W'(s);
`else
        return OUT_W'(u);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [30:0] d);
        in_valid = v;
        in_data  = d;
        step();
    endtask

    task automatic do_start(input logic [9:0] len);
        start    = 1'b1;
        acc_len  = len;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== '0) begin
            n_bad++;
            $display("FAIL reset: busy=%b sum_valid=%b sum_out=%0h, want 0/0/0", busy, sum_valid, sum_out);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_words();
        int d0;
        logic [OUT_W-1:0] exp;
        exp = pick(124, 124);
        do_start(10'd4);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_busy_after_start: got %b want 1", busy);
        end
        d0 = dumps;
        for (int i = 0; i < 4; i++) cyc(1'b1, ONES);
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_t2: sum_valid=%b busy=%b want 0/1", sum_valid, busy);
        end
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_dump: sum_valid=%b sum_out=%0h busy=%b want 1/%0h/0", sum_valid, sum_out, busy, exp);
        end
        step();
        n_cmp++;
        if (sum_valid !== 1'b0 || sum_out !== exp || dumps != d0 + 1) begin
            n_bad++;
            $display("FAIL full_hold: sum_valid=%b sum_out=%0h dumps=%0d want 0/%0h/%0d", sum_valid, sum_out, dumps - d0, exp, 1);
        end
    endtask

    task automatic test_gaps();
        logic [OUT_W-1:0] exp;
        exp = pick(32, -29);
        do_start(10'd3);
        cyc(1'b1, 31'h0);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        cyc(1'b1, 31'h1);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        cyc(1'b1, ONES);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp) begin
            n_bad++;
            $display("FAIL gaps_dump: sum_valid=%b sum_out=%0h want 1/%0h", sum_valid, sum_out, exp);
        end
        step();
    endtask

    task automatic test_zero_len();
        logic [OUT_W-1:0] exp;
        exp = pick(16, 1);
        do_start(10'd0);
        cyc(1'b1, 31'h5555_5555);
        n_cmp++;
        if (sum_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_len_early: sum_valid=%b want 0", sum_valid);
        end
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp) begin
            n_bad++;
            $display("FAIL zero_len_dump: sum_valid=%b sum_out=%0h want 1/%0h", sum_valid, sum_out, exp);
        end
        step();
    endtask

    task automatic test_abort();
        int d0;
        logic [OUT_W-1:0] exp;
        exp = pick(2, -58);
        d0 = dumps;
        do_start(10'd5);
        for (int i = 0; i < 3; i++) cyc(1'b1, ONES);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        do_start(10'd2);
        cyc(1'b1, 31'h1);
        cyc(1'b1, 31'h1);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp) begin
            n_bad++;
            $display("FAIL abort_dump: sum_valid=%b sum_out=%0h want 1/%0h", sum_valid, sum_out, exp);
        end
        step();
        n_cmp++;
        if (dumps != d0 + 1) begin
            n_bad++;
            $display("FAIL abort_dump_count: got %0d want 1", dumps - d0);
        end
    endtask

    task automatic test_max_len();
        logic early;
        logic [OUT_W-1:0] exp;
        exp = pick(31713, 31713);
        early = 1'b0;
        do_start(10'd1023);
        for (int i = 0; i < 1023; i++) begin
            cyc(1'b1, ONES);
            if (sum_valid === 1'b1) early = 1'b1;
        end
        cyc(1'b0, '0);
        n_cmp++;
        if (early !== 1'b0 || sum_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL max_pre_dump: early=%b sum_valid=%b busy=%b want 0/0/1", early, sum_valid, busy);
        end
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL max_dump: sum_valid=%b sum_out=%0h busy=%b want 1/%0h/0", sum_valid, sum_out, busy, exp);
        end
        step();
    endtask

    task automatic test_rst_mid_run();
        int d0;
        d0 = dumps;
        do_start(10'd2);
        cyc(1'b1, ONES);
        cyc(1'b1, ONES);
        cyc(1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (sum_valid !== 1'b0 || sum_out !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_run: sum_valid=%b sum_out=%0h busy=%b want 0/0/0", sum_valid, sum_out, busy);
        end
        step();
        step();
        n_cmp++;
        if (dumps != d0) begin
            n_bad++;
            $display("FAIL rst_no_dump: got %0d dumps want 0", dumps - d0);
        end
    endtask

    task automatic test_start_at_dump();
        int d0;
        logic [OUT_W-1:0] exp;
        exp = pick(2, -27);
        d0 = dumps;
        do_start(10'd2);
        cyc(1'b1, ONES);
        cyc(1'b1, ONES);
        cyc(1'b0, '0);
        // Final S2 beat of the old run is present now; restart with a len-1 run.
        start    = 1'b1;
        acc_len  = 10'd1;
        in_valid = 1'b1;
        in_data  = 31'h3;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        n_cmp++;
        if (sum_valid !== 1'b0 || busy !== 1'b1 || sum_out !== '0) begin
            n_bad++;
            $display("FAIL start_at_dump_suppress: sum_valid=%b busy=%b sum_out=%0h want 0/1/0", sum_valid, busy, sum_out);
        end
        step();
        step();
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp) begin
            n_bad++;
            $display("FAIL start_at_dump_new_run: sum_valid=%b sum_out=%0h want 1/%0h", sum_valid, sum_out, exp);
        end
        step();
        n_cmp++;
        if (dumps != d0 + 1) begin
            n_bad++;
            $display("FAIL start_at_dump_count: got %0d want 1", dumps - d0);
        end
    endtask

    task automatic test_idle_traffic();
        int d0;
        logic [OUT_W-1:0] exp;
        exp = pick(1, -29);
        d0 = dumps;
        for (int i = 0; i < 3; i++) cyc(1'b1, ONES);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0);
        n_cmp++;
        if (dumps != d0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_traffic: dumps=%0d busy=%b want 0/0", dumps - d0, busy);
        end
        do_start(10'd1);
        cyc(1'b1, 31'h1);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== exp) begin
            n_bad++;
            $display("FAIL idle_then_run: sum_valid=%b sum_out=%0h want 1/%0h", sum_valid, sum_out, exp);
        end
        step();
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        dumps    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        acc_len  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_full_words();
        test_gaps();
        test_zero_len();
        test_abort();
        test_max_len();
        test_rst_mid_run();
        test_start_at_dump();
        test_idle_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
